// File: rtl/img_ram_writer.sv
// Frame-buffer writer: takes a raster-order 4-bit pixel stream and issues one image-RAM write
// per accepted pixel, flagging frame completion and frames aborted by an early start-of-frame.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a start-of-frame pixel; other pixels are dropped
// S_WRITE | frame in progress, one write per accepted pixel
// S_DONE  | one-cycle gap after the last pixel, pix_ready held low
module img_ram_writer #(
    parameter int IMG_W  = 400,
    parameter int IMG_H  = 300,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [3:0]        pix_data,
    output logic              pix_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_din,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_pix_ready;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [3:0]          r_ram_din;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_frame_err;

    state_t              w_state_nxt;
    logic [XW-1:0]       w_x_nxt;
    logic [YW-1:0]       w_y_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_ram_addr_nxt;
    logic [3:0]          w_ram_din_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_accept;
    logic                w_last;

    assign w_accept = pix_valid & r_pix_ready;
    assign w_last   = (r_x == X_LAST) && (r_y == Y_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_addr_nxt     = r_addr;
        w_we_nxt       = 1'b0;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_din_nxt  = r_ram_din;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && pix_sof) begin
                    w_we_nxt       = 1'b1;
                    w_ram_addr_nxt = '0;
                    w_ram_din_nxt  = pix_data;
                    w_x_nxt        = XW'(1);
                    w_y_nxt        = '0;
                    w_addr_nxt     = ADDR_W'(1);
                    w_state_nxt    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_accept) begin
                    w_we_nxt      = 1'b1;
                    w_ram_din_nxt = pix_data;
                    // An early SOF wins over completion, even on the final pixel position
                    if (pix_sof) begin
                        w_err_nxt      = 1'b1;
                        w_ram_addr_nxt = '0;
                        w_x_nxt        = XW'(1);
                        w_y_nxt        = '0;
                        w_addr_nxt     = ADDR_W'(1);
                    end else begin
                        w_ram_addr_nxt = r_addr;
                        if (w_last) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_addr_nxt = r_addr + ADDR_W'(1);
                            if (r_x == X_LAST) begin
                                w_x_nxt = '0;
                                w_y_nxt = r_y + YW'(1);
                            end else begin
                                w_x_nxt = r_x + XW'(1);
                            end
                        end
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_pix_ready  <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_addr       <= w_addr_nxt;
            r_pix_ready  <= (w_state_nxt != S_DONE);
            r_ram_we     <= w_we_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_din    <= w_ram_din_nxt;
            r_busy       <= (w_state_nxt == S_WRITE);
            r_frame_done <= w_done_nxt;
            r_frame_err  <= w_err_nxt;
        end
    end

    assign pix_ready  = r_pix_ready;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_din    = r_ram_din;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_img_ram_writer.sv
// Bench for img_ram_writer on a reduced 40x30 frame, with a pixel-count reference model
// of the frame writer driven alongside the DUT.
module tb_img_ram_writer;

    localparam int W    = 40;
    localparam int H    = 30;
    localparam int AW   = 11;
    localparam int NPIX = W * H;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_sof   = 1'b0;
    logic [3:0]    pix_data  = 4'h0;
    logic          pix_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_din;
    logic          busy;
    logic          frame_done;
    logic          frame_err;

    img_ram_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: frame in progress plus index of the next pixel in raster order
    bit         m_in_frame, m_ready, m_we, m_done, m_err;
    int         m_n, m_addr;
    logic [3:0] m_din;

    int          obs_addr[$];
    logic [3:0]  obs_din[$];
    int          n_done, n_err, n_rdy_low, vec_bad, n_timeout, done_addr;
    logic [AW+8:0] bad_got, bad_exp;
    logic [AW+8:0] dut_vec;

    assign dut_vec = {ram_we, ram_addr, ram_din, frame_done, frame_err, busy, pix_ready};

    function automatic logic [AW+8:0] model_vec();
        return {m_we, AW'(m_addr), m_din, m_done, m_err, m_in_frame, m_ready};
    endfunction

    task automatic step(input bit v, input bit s, input logic [3:0] d, input bit rst, output bit acc);
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        rst_n     = !rst;
        @(posedge clk);
        acc = 1'b0;
        if (rst) begin
            m_in_frame = 0; m_n = 0; m_ready = 0; m_we = 0;
            m_addr = 0; m_din = 4'h0; m_done = 0; m_err = 0;
        end else begin
            acc = v && m_ready;
            m_we = 0; m_done = 0; m_err = 0; m_ready = 1;
            if (acc && s) begin
                m_err = m_in_frame;
                m_we = 1; m_addr = 0; m_din = d;
                m_in_frame = 1; m_n = 1;
            end else if (acc && m_in_frame) begin
                m_we = 1; m_addr = m_n; m_din = d;
                if (m_n == NPIX - 1) begin
                    m_done = 1; m_in_frame = 0; m_ready = 0;
                end else begin
                    m_n++;
                end
            end
        end
        #1;
    endtask

    task automatic observe();
        if (ram_we) begin
            obs_addr.push_back(int'(ram_addr));
            obs_din.push_back(ram_din);
        end
        if (frame_done) begin
            n_done++;
            done_addr = ram_we ? int'(ram_addr) : -1;
        end
        if (frame_err) n_err++;
        if (!pix_ready) n_rdy_low++;
        if (dut_vec !== model_vec()) begin
            if (vec_bad == 0) begin
                bad_got = dut_vec;
                bad_exp = model_vec();
            end
            vec_bad++;
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_din.delete();
        n_done = 0; n_err = 0; n_rdy_low = 0; vec_bad = 0; n_timeout = 0; done_addr = -1;
    endtask

    task automatic go_idle();
        bit acc;
        step(0, 0, 4'h0, 1, acc);
        step(0, 0, 4'h0, 0, acc);
    endtask

    // Sends pixels 0..count-1 (SOF on the first, data = index[3:0]), holding a stalled pixel.
    task automatic drive_frame(input bit gaps, input int count, output int cycles);
        int idx = 0;
        bit acc, v, pending;
        pending = 0;
        cycles  = 0;
        while (idx < count && cycles < 4 * count + 20) begin
            v = pending ? 1'b1 : (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
            step(v, idx == 0, 4'(idx), 0, acc);
            observe();
            cycles++;
            if (acc) idx++;
            pending = v && !acc;
        end
        if (idx < count) n_timeout++;
    endtask

    task automatic test_reset();
        bit acc;
        clear_obs();
        step(1, 1, 4'h7, 1, acc);
        step(0, 0, 4'h0, 1, acc);
        n_checks++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", dut_vec);
        end
        step(0, 0, 4'h0, 0, acc);
        n_checks++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got ready=%b busy=%b, want 1/0", pix_ready, busy);
        end
    endtask

    task automatic test_idle_garbage();
        bit acc;
        clear_obs();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 4'($urandom_range(0, 15)), 0, acc);
            observe();
        end
        n_checks++;
        if (obs_addr.size() != 0 || n_done != 0 || n_err != 0) begin
            n_fail++;
            $display("FAIL idle_garbage: got writes=%0d done=%0d err=%0d, want 0/0/0",
                     obs_addr.size(), n_done, n_err);
        end
        n_checks++;
        if (vec_bad != 0) begin
            n_fail++;
            $display("FAIL idle_cycle_match: got %0d bad cycles (first %h vs %h), want 0",
                     vec_bad, bad_got, bad_exp);
        end
    endtask

    task automatic test_full_frame(input bit gaps, input string tag);
        bit acc;
        int cyc, seq_bad;
        go_idle();
        clear_obs();
        drive_frame(gaps, NPIX, cyc);
        step(0, 0, 4'h0, 0, acc);
        observe();
        step(0, 0, 4'h0, 0, acc);
        observe();
        seq_bad = 0;
        for (int i = 0; i < obs_addr.size(); i++)
            if (obs_addr[i] != i || obs_din[i] !== 4'(i)) seq_bad++;
        n_checks++;
        if (n_timeout != 0 || obs_addr.size() != NPIX || seq_bad != 0) begin
            n_fail++;
            $display("FAIL %s_write_seq: got timeout=%0d writes=%0d out_of_order=%0d, want 0/%0d/0",
                     tag, n_timeout, obs_addr.size(), seq_bad, NPIX);
        end
        n_checks++;
        if (n_done != 1 || done_addr != NPIX - 1 || n_err != 0) begin
            n_fail++;
            $display("FAIL %s_done: got done=%0d at addr %0d err=%0d, want 1 at %0d err 0",
                     tag, n_done, done_addr, n_err, NPIX - 1);
        end
        n_checks++;
        if (n_rdy_low != 1) begin
            n_fail++;
            $display("FAIL %s_done_bubble: got %0d ready-low cycles, want 1", tag, n_rdy_low);
        end
        n_checks++;
        if (vec_bad != 0) begin
            n_fail++;
            $display("FAIL %s_cycle_match: got %0d bad cycles (first %h vs %h), want 0",
                     tag, vec_bad, bad_got, bad_exp);
        end
    endtask

    task automatic test_early_sof();
        bit acc;
        int cyc;
        go_idle();
        clear_obs();
        drive_frame(0, 501, cyc);
        step(1, 1, 4'hA, 0, acc);
        observe();
        n_checks++;
        if (frame_err !== 1'b1 || ram_we !== 1'b1 || ram_addr !== '0 || ram_din !== 4'hA || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL early_sof_abort: got err=%b we=%b addr=%0d din=%h busy=%b, want 1/1/0/a/1",
                     frame_err, ram_we, ram_addr, ram_din, busy);
        end
        step(1, 0, 4'h5, 0, acc);
        observe();
        n_checks++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(1) || ram_din !== 4'h5 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL early_sof_restart: got we=%b addr=%0d din=%h err=%b, want 1/1/5/0",
                     ram_we, ram_addr, ram_din, frame_err);
        end
        n_checks++;
        if (obs_addr.size() <= W || obs_addr[W] != W || obs_addr[W-1] != W - 1) begin
            n_fail++;
            $display("FAIL line_wrap: got %0d writes, addr[%0d]=%0d, want addr %0d",
                     obs_addr.size(), W, (obs_addr.size() > W) ? obs_addr[W] : -1, W);
        end
        n_checks++;
        if (n_err != 1 || n_done != 0 || vec_bad != 0) begin
            n_fail++;
            $display("FAIL early_sof_flags: got err=%0d done=%0d bad_cycles=%0d, want 1/0/0",
                     n_err, n_done, vec_bad);
        end
    endtask

    task automatic test_sof_on_last();
        bit acc;
        int cyc;
        go_idle();
        clear_obs();
        drive_frame(0, NPIX - 1, cyc);
        step(1, 1, 4'h3, 0, acc);
        observe();
        n_checks++;
        if (frame_err !== 1'b1 || frame_done !== 1'b0 || ram_addr !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sof_on_last: got err=%b done=%b addr=%0d busy=%b, want 1/0/0/1",
                     frame_err, frame_done, ram_addr, busy);
        end
        n_checks++;
        if (n_done != 0 || vec_bad != 0) begin
            n_fail++;
            $display("FAIL sof_on_last_flags: got done=%0d bad_cycles=%0d, want 0/0", n_done, vec_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit acc;
        int cyc;
        go_idle();
        clear_obs();
        drive_frame(0, 1000, cyc);
        step(1, 0, 4'h9, 1, acc);
        n_checks++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_frame_outputs: got %h, want 0", dut_vec);
        end
        clear_obs();
        step(0, 0, 4'h0, 0, acc);
        observe();
        drive_frame(0, 3, cyc);
        n_checks++;
        if (obs_addr.size() != 3 || obs_addr[0] != 0 || obs_addr[2] != 2 || n_err != 0 || n_done != 0) begin
            n_fail++;
            $display("FAIL reset_mid_frame_restart: got writes=%0d err=%0d done=%0d, want 3 from addr 0, no flags",
                     obs_addr.size(), n_err, n_done);
        end
        n_checks++;
        if (vec_bad != 0) begin
            n_fail++;
            $display("FAIL reset_mid_frame_cycle_match: got %0d bad cycles (first %h vs %h), want 0",
                     vec_bad, bad_got, bad_exp);
        end
    endtask

    task automatic test_back_to_back();
        int cyc1, cyc2, seq_bad;
        go_idle();
        clear_obs();
        drive_frame(0, NPIX, cyc1);
        drive_frame(0, NPIX, cyc2);
        seq_bad = 0;
        for (int i = 0; i < obs_addr.size(); i++)
            if (obs_addr[i] != i % NPIX || obs_din[i] !== 4'(i % NPIX)) seq_bad++;
        n_checks++;
        if (cyc2 != NPIX + 1) begin
            n_fail++;
            $display("FAIL b2b_sof_stall: got %0d cycles for frame 2, want %0d", cyc2, NPIX + 1);
        end
        n_checks++;
        if (n_done != 2 || n_err != 0 || obs_addr.size() != 2 * NPIX || seq_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_frames: got done=%0d err=%0d writes=%0d out_of_order=%0d, want 2/0/%0d/0",
                     n_done, n_err, obs_addr.size(), seq_bad, 2 * NPIX);
        end
        n_checks++;
        if (vec_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_cycle_match: got %0d bad cycles (first %h vs %h), want 0",
                     vec_bad, bad_got, bad_exp);
        end
    endtask

    initial begin
        test_reset();
        test_idle_garbage();
        test_full_frame(0, "full_frame");
        test_early_sof();
        test_sof_on_last();
        test_full_frame(1, "valid_gaps");
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/img_ram_writer.md
# img_ram_writer

Frame-buffer writer feeding the 400×300×4-bit image memory that the display path reads. It accepts a pixel stream (4-bit palette index per pixel, valid/ready handshake, start-of-frame flag) in raster order, tracks x/y position, and issues one RAM write per accepted pixel. It reports frame completion and frame errors. It sits in the `clk2` pixel-clock domain, between a pixel source (UART loader, pattern generator) and the write port of a dual-port image RAM.

## Interface
- `IMG_W`, default 400: pixels per line.
- `IMG_H`, default 300: lines per frame.
- `ADDR_W`, default 17: RAM address width. Must satisfy `IMG_W*IMG_H <= 2^ADDR_W`.

Ports:
- `clk`  in  1  pixel clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `pix_valid`  in  1  `pix_data` / `pix_sof` are valid this cycle.
- `pix_sof`  in  1  marks the first pixel of a frame; only meaningful when `pix_valid`=1.
- `pix_data`  in  4  pixel palette index.
- `pix_ready`  out  1  the block accepts a pixel this cycle. Accept = `pix_valid & pix_ready`.
- `ram_we`  out  1  write strobe to the image RAM.
- `ram_addr`  out  ADDR_W  write address, equal to y*IMG_W + x.
- `ram_din`  out  4  write data.
- `busy`  out  1  a frame is in progress (state WRITE).
- `frame_done`  out  1  one-cycle pulse: the last pixel of a frame was written.
- `frame_err`  out  1  one-cycle pulse: the current frame was aborted by an early `pix_sof`.

## Operation
State machine with three states:
- **IDLE**
  - `pix_ready`=1.
  - An accepted pixel with `pix_sof`=0 is discarded: no write, no error.
  - An accepted pixel with `pix_sof`=1 is written at address 0. Then x=1, y=0, and the state moves to WRITE.
- **WRITE**
  - `pix_ready`=1.
  - Each accept with `pix_sof`=0 writes at the running address, then advances it.
  - x wraps from IMG_W-1 to 0 and y increments at that wrap.
  - The address is an incrementing counter; no multiplier is used.
- **DONE**
  - Lasts exactly one cycle with `pix_ready`=0, then the state returns to IDLE.

Frame completion and errors:
- Accepting the pixel at x=IMG_W-1, y=IMG_H-1 writes address IMG_W*IMG_H-1 (119999 at default parameters) and moves the state to DONE.
- An accept with `pix_sof`=1 while in WRITE aborts the frame:
  - `frame_err` pulses.
  - That pixel is written at address 0.
  - x=1, y=0, and the state stays in WRITE.
- If `pix_sof`=1 arrives on the final pixel position, it is treated as an abort, not a completion.

Other rules:
- `pix_valid`=0 cycles in WRITE hold all counters. There is no timeout.
- `pix_data` is never altered. `ram_din` is the accepted `pix_data`.
- Address never exceeds IMG_W*IMG_H-1.
- Reset in any state returns to IDLE immediately. A partially written frame is abandoned with no `frame_err` or `frame_done`.

## Timing
- All outputs are registered.
- Values after reset (`rst_n` low at a clock edge):
  - `pix_ready`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `busy`=0, `frame_done`=0, `frame_err`=0.
  - `pix_ready` rises on the first edge with `rst_n`=1.
- Write latency: an accept at edge N produces `ram_we`=1, with the matching `ram_addr` and `ram_din`, from edge N+1 for exactly one cycle.
- `ram_we` is 0 in every cycle that did not follow an accept-that-writes.
- `ram_addr` and `ram_din` hold their last values when `ram_we`=0.
- `frame_done` is high in the same cycle as the `ram_we` for the last pixel.
- `frame_err` is high in the same cycle as the `ram_we` for the aborting pixel (address 0).
- `busy` timing:
  - Goes 1 in the cycle after the SOF accept.
  - Goes 0 in the cycle after the last-pixel accept, which is the DONE cycle.
- Throughput: one pixel per clock in WRITE. Between frames there is a one-cycle bubble (DONE, `pix_ready`=0).
- Handshake rule: the source holds `pix_valid`/`pix_data`/`pix_sof` stable while `pix_ready`=0. The block takes no action without an accept.

## Test plan
- **Full frame:** IDLE, SOF, then 120000 consecutive pixels with data = addr[3:0].
  - 120000 `ram_we` pulses at addresses 0..119999, in order, with matching data.
  - `frame_done` pulses once, together with addr 119999.
  - `busy` falls one cycle after the last accept; `pix_ready`=0 for exactly one cycle.
- **Idle garbage:** 10 pixels with `pix_sof`=0 before any SOF.
  - No `ram_we`, no flags, `busy`=0.
- **Early SOF:** SOF, 500 pixels, then SOF with data 0xA.
  - `frame_err` pulses with `ram_we` at addr 0 and din 0xA.
  - The next pixel is written at addr 1, which is x=1, y=0.
  - Line wrap is also checked: pixel 400 goes to addr 400, i.e. x=0, y=1.
- **Valid gaps:** full frame with `pix_valid` random at 50%.
  - Same address and data sequence as the full-frame case.
  - No write in any cycle not following an accept.
- **Reset mid-frame:** `rst_n`=0 for one cycle after 1000 pixels.
  - All outputs are 0 on the next cycle; no flags.
  - A following SOF restarts writing at addr 0.
- **Back-to-back frames:** two frames with SOF presented during the DONE cycle.
  - SOF is stalled one cycle and accepted in IDLE.
  - Two `frame_done` pulses, no `frame_err`.
